// File: rtl/stream_cmd_pkg.sv
// Op codes, command nibbles, FSM encoding and elaboration helpers shared by
// the stream command master and its timer.
package stream_cmd_pkg;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_CONV = 2'b11
  } op_e;

  localparam logic [3:0] NIB_WR   = 4'h1;
  localparam logic [3:0] NIB_RD   = 4'h2;
  localparam logic [3:0] NIB_CONV = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_HI,
    S_CMD_GAP,
    S_DAT_HI,
    S_DAT_GAP,
    S_WAIT_CONV,
    S_RESP
  } state_e;

  localparam int TMR_W = 16;

  // Phase lengths below 2 would let the controller miss a level, so clamp.
  function automatic logic [TMR_W-1:0] clamp_len(input int v, input int hi);
    int c;
    c = (v < 2) ? 2 : ((v > hi) ? hi : v);
    return TMR_W'(c);
  endfunction

  function automatic logic [7:0] cmd_byte(input op_e op, input logic [3:0] sel);
    logic [7:0] b;
    case (op)
      OP_WR:   b = {NIB_WR, sel};
      OP_RD:   b = {NIB_RD, 2'b00, sel[1:0]};
      OP_CONV: b = {NIB_CONV, 2'b00, sel[1:0]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded span.
module cycle_timer
  import stream_cmd_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/stream_cmd_master.sv
// Host-side initiator: turns one request into the command/data pulse pair on
// the controller's stsink port and reports the outcome as a one-cycle response.
module stream_cmd_master
  import stream_cmd_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int RD_HOLD   = 4,
  parameter int CONV_TMO  = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_sel,
  input  logic [7:0] req_data,
  output logic       stsinkvalid,
  output logic [7:0] stsinkdata,
  output logic       stsourceready,
  input  logic       stsinkready,
  input  logic       stsourcevalid,
  input  logic [7:0] stsourcedata,
  input  logic       conv_done,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [TMR_W-1:0] PULSE_L = clamp_len(PULSE_CYC, 255);
  localparam logic [TMR_W-1:0] GAP_L   = clamp_len(GAP_CYC, 255);
  localparam logic [TMR_W-1:0] RDH_L   = clamp_len(RD_HOLD, 255);
  localparam logic [TMR_W-1:0] TMO_L   = clamp_len(CONV_TMO, 65535);

  state_e            state, state_d;
  op_e               op_q;
  logic [7:0]        data_q;
  logic              accept;
  logic              conv_seen;
  logic              timeout;
  logic              tmr_load;
  logic              tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              sink_valid_d;
  logic [7:0]        sink_data_d;
  logic              unused_sink_ready;

  // The controller never back-pressures a pulse; stsinkready is observed only.
  assign unused_sink_ready = stsinkready;
  assign accept  = req_valid & req_ready;
  assign timeout = (state == S_WAIT_CONV) & tmr_done & ~(conv_seen | conv_done);

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state;
    tmr_load     = 1'b0;
    tmr_val      = PULSE_L;
    sink_valid_d = 1'b0;
    sink_data_d  = stsinkdata;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_op == OP_ILL) begin
            state_d = S_RESP;
          end else begin
            state_d      = S_CMD_HI;
            tmr_load     = 1'b1;
            tmr_val      = PULSE_L;
            sink_valid_d = 1'b1;
            sink_data_d  = cmd_byte(op_e'(req_op), req_sel);
          end
        end
      end
      S_CMD_HI: begin
        if (tmr_done) begin
          state_d  = S_CMD_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_L;
        end else begin
          sink_valid_d = 1'b1;
        end
      end
      S_CMD_GAP: begin
        if (tmr_done) begin
          state_d      = S_DAT_HI;
          tmr_load     = 1'b1;
          tmr_val      = (op_q == OP_RD) ? RDH_L : PULSE_L;
          sink_valid_d = 1'b1;
          sink_data_d  = (op_q == OP_WR) ? data_q : 8'h00;
        end
      end
      S_DAT_HI: begin
        if (tmr_done) begin
          state_d  = S_DAT_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_L;
        end else begin
          sink_valid_d = 1'b1;
        end
      end
      S_DAT_GAP: begin
        if (tmr_done) begin
          if (op_q == OP_CONV) begin
            state_d  = S_WAIT_CONV;
            tmr_load = 1'b1;
            tmr_val  = TMO_L;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT_CONV: begin
        if (conv_seen || conv_done || tmr_done) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      stsinkvalid   <= 1'b0;
      stsinkdata    <= 8'h00;
      stsourceready <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_err       <= 1'b0;
      conv_seen     <= 1'b0;
    end else begin
      state         <= state_d;
      req_ready     <= (state_d == S_IDLE);
      stsinkvalid   <= sink_valid_d;
      stsinkdata    <= sink_data_d;
      stsourceready <= 1'b1;
      rsp_valid     <= (state_d == S_RESP);
      if (accept) begin
        rsp_data <= 8'h00;
        rsp_err  <= (req_op == OP_ILL);
      end else if (state == S_DAT_HI && tmr_done && op_q == OP_RD) begin
        rsp_data <= stsourcedata;
        rsp_err  <= ~stsourcevalid;
      end else if (timeout) begin
        rsp_err <= 1'b1;
      end
      // A completion arriving during the data pulse or gap must not be lost.
      if (accept) begin
        conv_seen <= 1'b0;
      end else if (conv_done && (state inside {S_DAT_HI, S_DAT_GAP, S_WAIT_CONV})) begin
        conv_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(req_op);
      data_q <= req_data;
    end
  end

endmodule
